// File: rtl/sort_ctrl_pkg.sv
// Shared definitions for the sort-unit controller: FSM states, sort-unit
// command codes and the default sort depth.
package sort_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_DRAIN_REQ,
        S_DRAIN_CAP,
        S_DRAIN_HOLD,
        S_RELU,
        S_FIN
    } state_t;

    localparam logic [3:0] SIG_IDLE = 4'b0000;
    localparam logic [3:0] SIG_SORT = 4'b0001;
    localparam logic [3:0] SIG_RELU = 4'b0010;

    localparam int K_DEFAULT = 20;

endpackage

// File: rtl/sort_ctrl_obuf.sv
// Single-entry output register with valid/ready; a load wins over a
// simultaneous drain so back-to-back results are never dropped.
module sort_ctrl_obuf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [31:0]       i_index,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [31:0]       o_index
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [31:0]       r_index;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_index <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_index <= i_index;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_index = r_index;

endmodule

// File: rtl/sort_ctrl.sv
// Job controller for an external top-K sort unit: loads a stream into the
// unit, drains min(K, N) ranked results, or runs a registered pass-through job.
module sort_ctrl
    import sort_ctrl_pkg::*;
#(
    parameter int K      = K_DEFAULT,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cfg_mode,
    input  logic              cfg_asce,
    input  logic [CNT_W-1:0]  cfg_num,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] su_in,
    output logic [31:0]       su_index,
    output logic [3:0]        su_sig,
    output logic              su_asce,
    output logic              su_is_output,
    output logic              su_clear,
    input  logic [DATA_W-1:0] su_out,
    input  logic [31:0]       su_out_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       out_index
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] drain_len(input logic [CNT_W-1:0] num);
        logic [31:0] w_len;
        w_len = 32'(num);
        if (w_len > 32'(K)) w_len = 32'(K);
        return CNT_W'(w_len);
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_asce;
    logic [CNT_W-1:0]  r_num;
    logic [CNT_W-1:0]  r_drain_len;
    logic [CNT_W-1:0]  r_load_cnt;
    logic [CNT_W-1:0]  r_drain_cnt;
    logic [DATA_W-1:0] r_su_in;
    logic [31:0]       r_su_index;

    logic              w_out_hs;
    logic              w_relu_ready;
    logic              w_load_beat;
    logic              w_relu_beat;
    logic              w_su_beat;
    logic              w_obuf_load;
    logic [DATA_W-1:0] w_obuf_data;
    logic [31:0]       w_obuf_index;

    assign w_out_hs     = out_valid && out_ready;
    // Pass-through accepts only when the output slot is free or emptying now.
    assign w_relu_ready = (r_load_cnt != r_num) && (!out_valid || out_ready);
    assign w_load_beat  = (r_state == S_LOAD) && in_valid;
    assign w_relu_beat  = (r_state == S_RELU) && in_valid && w_relu_ready;
    assign w_su_beat    = w_load_beat || w_relu_beat;

    assign busy     = (r_state != S_IDLE);
    assign su_asce  = r_asce;
    assign su_in    = w_su_beat ? in_data : r_su_in;
    assign su_index = w_su_beat ? 32'(r_load_cnt) : r_su_index;

    always_comb begin
        w_state_nxt  = r_state;
        in_ready     = 1'b0;
        su_sig       = SIG_IDLE;
        su_is_output = 1'b0;
        su_clear     = 1'b0;
        done         = 1'b0;
        w_obuf_load  = 1'b0;
        w_obuf_data  = su_out;
        w_obuf_index = su_out_index;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (cfg_num == '0)  w_state_nxt = S_FIN;
                    else if (cfg_mode)  w_state_nxt = S_RELU;
                    else                w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                su_clear    = 1'b1;
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    su_sig = SIG_SORT;
                    if (r_load_cnt == r_num - CNT_ONE) w_state_nxt = S_DRAIN_REQ;
                end
            end
            S_DRAIN_REQ: begin
                su_is_output = 1'b1;
                su_sig       = SIG_SORT;
                w_state_nxt  = S_DRAIN_CAP;
            end
            S_DRAIN_CAP: begin
                w_obuf_load = 1'b1;
                w_state_nxt = S_DRAIN_HOLD;
            end
            S_DRAIN_HOLD: begin
                if (w_out_hs) begin
                    if (r_drain_cnt == r_drain_len - CNT_ONE) w_state_nxt = S_FIN;
                    else                                      w_state_nxt = S_DRAIN_REQ;
                end
            end
            S_RELU: begin
                su_sig   = SIG_RELU;
                in_ready = w_relu_ready;
                if (w_relu_beat) begin
                    w_obuf_load  = 1'b1;
                    w_obuf_data  = in_data;
                    w_obuf_index = 32'(r_load_cnt);
                end
                if (w_out_hs && (r_drain_cnt == r_num - CNT_ONE)) w_state_nxt = S_FIN;
            end
            S_FIN: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_asce      <= 1'b0;
            r_num       <= '0;
            r_drain_len <= '0;
            r_load_cnt  <= '0;
            r_drain_cnt <= '0;
            r_su_in     <= '0;
            r_su_index  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && start) begin
                r_asce      <= cfg_asce;
                r_num       <= cfg_num;
                r_drain_len <= drain_len(cfg_num);
                r_load_cnt  <= '0;
                r_drain_cnt <= '0;
            end
            if (w_su_beat) begin
                r_su_in    <= in_data;
                r_su_index <= 32'(r_load_cnt);
                r_load_cnt <= r_load_cnt + CNT_ONE;
            end
            if (w_out_hs && (r_state == S_DRAIN_HOLD || r_state == S_RELU))
                r_drain_cnt <= r_drain_cnt + CNT_ONE;
        end
    end

    sort_ctrl_obuf #(
        .DATA_W (DATA_W)
    ) u_obuf (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_obuf_load),
        .i_data  (w_obuf_data),
        .i_index (w_obuf_index),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_data  (out_data),
        .o_index (out_index)
    );

endmodule
